// File: rtl/dimmer_pkg.sv
// rtl/dimmer_pkg.sv - shared channel state type and timing defaults for the dimmer button front-end
package dimmer_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HOLD   = 2'd1,
      REPEAT = 2'd2,
      LOCK   = 2'd3
   } state_t;

   // 10 ms debounce, 500 ms first repeat, 100 ms repeat period at 100 MHz
   localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;
   localparam int REPEAT_DELAY_DEF    = 50_000_000;
   localparam int REPEAT_PERIOD_DEF   = 10_000_000;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sync_debounce.sv
// rtl/sync_debounce.sv - two-flop synchroniser followed by a counter debounce, one button
module sync_debounce
   import dimmer_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
)
(
   input  logic clk_sys,
   input  logic rst,
   input  logic raw,
   output logic level
);

   localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync_meta;
   logic          sync_out;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk_sys) begin
      if (rst) begin
         sync_meta <= 1'b0;
         sync_out  <= 1'b0;
         cnt       <= '0;
         level     <= 1'b0;
      end else begin
         sync_meta <= raw;
         sync_out  <= sync_meta;
         // the toggling sample is itself the DEBOUNCE_CYCLES-th differing one
         if (sync_out == level) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            level <= ~level;
            cnt   <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - debounced up/down buttons to single-cycle dimmer commands with auto-repeat and lockout
module button_conditioner
   import dimmer_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter bit REPEAT_EN       = 1'b1,
   parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
   parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
)
(
   input  logic clk_sys,
   input  logic rst,
   input  logic u_raw,
   input  logic d_raw,
   output logic u,
   output logic d,
   output logic u_level,
   output logic d_level
);

   localparam int            RW          = max2($clog2(max2(REPEAT_DELAY, REPEAT_PERIOD)), 1);
   localparam logic [RW-1:0] DELAY_LOAD  = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] PERIOD_LOAD = RW'(REPEAT_PERIOD - 1);

   logic [1:0]    lvl;
   logic          lock;
   logic [1:0]    pulse;
   state_t        state [2];
   logic [RW-1:0] rcnt  [2];

   sync_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) up_deb (
      .clk_sys (clk_sys),
      .rst     (rst),
      .raw     (u_raw),
      .level   (u_level)
   );

   sync_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) down_deb (
      .clk_sys (clk_sys),
      .rst     (rst),
      .raw     (d_raw),
      .level   (d_level)
   );

   assign lvl  = {d_level, u_level};
   assign lock = &lvl;

   // channel 0 is up, channel 1 is down; a level high in IDLE is always a new press
   always_ff @(posedge clk_sys) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            state[i] <= IDLE;
            rcnt[i]  <= '0;
         end
         pulse <= 2'b00;
      end else begin
         for (int i = 0; i < 2; i++) begin
            pulse[i] <= 1'b0;
            if (lock) begin
               state[i] <= LOCK;
            end else begin
               case (state[i])
                  IDLE: begin
                     if (lvl[i]) begin
                        pulse[i] <= 1'b1;
                        rcnt[i]  <= DELAY_LOAD;
                        state[i] <= HOLD;
                     end
                  end
                  HOLD: begin
                     if (!lvl[i]) begin
                        state[i] <= IDLE;
                     end else if (rcnt[i] != '0) begin
                        rcnt[i] <= rcnt[i] - RW'(1);
                     end else if (REPEAT_EN) begin
                        pulse[i] <= 1'b1;
                        rcnt[i]  <= PERIOD_LOAD;
                        state[i] <= REPEAT;
                     end
                  end
                  REPEAT: begin
                     if (!lvl[i]) begin
                        state[i] <= IDLE;
                     end else if (rcnt[i] != '0) begin
                        rcnt[i] <= rcnt[i] - RW'(1);
                     end else begin
                        pulse[i] <= 1'b1;
                        rcnt[i]  <= PERIOD_LOAD;
                     end
                  end
                  LOCK: begin
                     if (!lvl[i]) begin
                        state[i] <= IDLE;
                     end
                  end
                  default: state[i] <= IDLE;
               endcase
            end
         end
      end
   end

   assign u = pulse[0];
   assign d = pulse[1];

   u_d_exclusive: assert property (@(posedge clk_sys) !(u && d));

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - directed self-checking bench for button_conditioner
module tb_button_conditioner;

   logic clk_sys = 1'b0;
   logic rst     = 1'b1;
   logic u_raw   = 1'b0;
   logic d_raw   = 1'b0;
   logic u, d, u_level, d_level;
   logic u2, d2, u2_level, d2_level;

   int cyc    = 0;
   int checks = 0;
   int errors = 0;
   int u_q[$];
   int d_q[$];
   int d2_q[$];

   button_conditioner #(
      .DEBOUNCE_CYCLES (4),
      .REPEAT_EN       (1'b1),
      .REPEAT_DELAY    (20),
      .REPEAT_PERIOD   (8)
   ) dut (
      .clk_sys (clk_sys),
      .rst     (rst),
      .u_raw   (u_raw),
      .d_raw   (d_raw),
      .u       (u),
      .d       (d),
      .u_level (u_level),
      .d_level (d_level)
   );

   button_conditioner #(
      .DEBOUNCE_CYCLES (4),
      .REPEAT_EN       (1'b0),
      .REPEAT_DELAY    (20),
      .REPEAT_PERIOD   (8)
   ) dut_norep (
      .clk_sys (clk_sys),
      .rst     (rst),
      .u_raw   (u_raw),
      .d_raw   (d_raw),
      .u       (u2),
      .d       (d2),
      .u_level (u2_level),
      .d_level (d2_level)
   );

   always #5 clk_sys = ~clk_sys;

   always @(posedge clk_sys) cyc <= cyc + 1;

   // log the edge number at which each pulse was registered
   always @(negedge clk_sys) begin
      if (u)  u_q.push_back(cyc);
      if (d)  d_q.push_back(cyc);
      if (d2) d2_q.push_back(cyc);
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk_sys);
   endtask

   task automatic test_reset();
      int k;
      rst   = 1'b1;
      u_raw = 1'b1;
      d_raw = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_sys);
         checks++;
         if ({u, d, u_level, d_level, u2, d2, u2_level, d2_level} !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: got %b%b%b%b%b%b%b%b expected 00000000",
                     u, d, u_level, d_level, u2, d2, u2_level, d2_level);
         end
      end
      rst   = 1'b0;
      d_raw = 1'b0;
      k     = cyc + 1;
      u_q.delete();
      d_q.delete();
      for (int i = 0; i < 16; i++) begin
         @(negedge clk_sys);
         if (cyc == k + 4) begin
            checks++;
            if (u_level !== 1'b0) begin
               errors++;
               $display("FAIL reset_level_early: got %b expected 0", u_level);
            end
         end
         if (cyc == k + 5) begin
            checks++;
            if (u_level !== 1'b1) begin
               errors++;
               $display("FAIL reset_level_rise: got %b expected 1", u_level);
            end
         end
      end
      checks++;
      if (u_q.size() != 1 || u_q[0] != k + 6) begin
         errors++;
         $display("FAIL reset_first_pulse: got %0d pulses (first at %0d) expected 1 at %0d",
                  u_q.size(), (u_q.size() > 0) ? u_q[0] : -1, k + 6);
      end
      u_raw = 1'b0;
      tick(15);
      checks++;
      if (u_q.size() != 1 || d_q.size() != 0) begin
         errors++;
         $display("FAIL reset_release: got u=%0d d=%0d pulses expected u=1 d=0",
                  u_q.size(), d_q.size());
      end
   endtask

   task automatic test_glitch();
      u_q.delete();
      u_raw = 1'b1;
      tick(3);
      u_raw = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk_sys);
         checks++;
         if (u_level !== 1'b0) begin
            errors++;
            $display("FAIL glitch_level cycle %0d: got %b expected 0", i, u_level);
         end
      end
      checks++;
      if (u_q.size() != 0) begin
         errors++;
         $display("FAIL glitch_pulse: got %0d pulses expected 0", u_q.size());
      end
   endtask

   task automatic test_bounce();
      int k;
      u_q.delete();
      for (int i = 0; i < 20; i++) begin
         u_raw = ((i / 2) % 2 == 0);
         tick(1);
      end
      u_raw = 1'b1;
      k     = cyc + 1;
      tick(8);
      for (int j = 0; j < 8; j++) begin
         u_raw = ((j / 2) % 2 == 1);
         tick(1);
      end
      u_raw = 1'b0;
      tick(20);
      checks++;
      if (u_q.size() != 1 || u_q[0] != k + 6) begin
         errors++;
         $display("FAIL bounce_pulse: got %0d pulses (first at %0d) expected 1 at %0d",
                  u_q.size(), (u_q.size() > 0) ? u_q[0] : -1, k + 6);
      end
      checks++;
      if (u_level !== 1'b0) begin
         errors++;
         $display("FAIL bounce_release_level: got %b expected 0", u_level);
      end
   endtask

   task automatic test_repeat();
      int k, t0;
      int offs [6];
      offs = '{0, 20, 28, 36, 44, 52};
      d_q.delete();
      d2_q.delete();
      u_q.delete();
      d_raw = 1'b1;
      k     = cyc + 1;
      t0    = k + 6;
      while (cyc < t0 + 50) @(negedge clk_sys);
      d_raw = 1'b0;
      tick(30);
      checks++;
      if (d_q.size() != 6) begin
         errors++;
         $display("FAIL repeat_count: got %0d pulses expected 6", d_q.size());
      end
      for (int i = 0; i < 6; i++) begin
         if (i < d_q.size()) begin
            checks++;
            if (d_q[i] != t0 + offs[i]) begin
               errors++;
               $display("FAIL repeat_time[%0d]: got %0d expected %0d", i, d_q[i], t0 + offs[i]);
            end
         end
      end
      checks++;
      if (d2_q.size() != 1 || d2_q[0] != t0) begin
         errors++;
         $display("FAIL norepeat_pulse: got %0d pulses (first at %0d) expected 1 at %0d",
                  d2_q.size(), (d2_q.size() > 0) ? d2_q[0] : -1, t0);
      end
      checks++;
      if (u_q.size() != 0) begin
         errors++;
         $display("FAIL repeat_no_up: got %0d up pulses expected 0", u_q.size());
      end
   endtask

   task automatic test_lockout();
      int k, k3;
      u_q.delete();
      d_q.delete();
      u_raw = 1'b1;
      k     = cyc + 1;
      tick(10);
      checks++;
      if (u_q.size() != 1 || u_q[0] != k + 6) begin
         errors++;
         $display("FAIL lock_first_up: got %0d pulses (first at %0d) expected 1 at %0d",
                  u_q.size(), (u_q.size() > 0) ? u_q[0] : -1, k + 6);
      end
      u_q.delete();
      d_raw = 1'b1;
      tick(10);
      checks++;
      if ({u_level, d_level} !== 2'b11) begin
         errors++;
         $display("FAIL lock_levels: got %b%b expected 11", u_level, d_level);
      end
      tick(15);
      u_raw = 1'b0;
      tick(15);
      checks++;
      if (u_q.size() != 0 || d_q.size() != 0) begin
         errors++;
         $display("FAIL lock_silent: got u=%0d d=%0d pulses expected 0 0", u_q.size(), d_q.size());
      end
      d_raw = 1'b0;
      tick(10);
      d_raw = 1'b1;
      k3    = cyc + 1;
      tick(10);
      d_raw = 1'b0;
      tick(15);
      checks++;
      if (d_q.size() != 1 || d_q[0] != k3 + 6) begin
         errors++;
         $display("FAIL lock_repress: got %0d pulses (first at %0d) expected 1 at %0d",
                  d_q.size(), (d_q.size() > 0) ? d_q[0] : -1, k3 + 6);
      end
      checks++;
      if (u_q.size() != 0) begin
         errors++;
         $display("FAIL lock_repress_up: got %0d up pulses expected 0", u_q.size());
      end
   endtask

   task automatic test_reset_mid();
      int k, t0;
      d_q.delete();
      u_q.delete();
      d_raw = 1'b1;
      k     = cyc + 1;
      t0    = k + 6;
      while (cyc < t0 + 25) @(negedge clk_sys);
      rst = 1'b1;
      @(negedge clk_sys);
      checks++;
      if ({d, d_level} !== 2'b00) begin
         errors++;
         $display("FAIL midreset_outputs: got d=%b d_level=%b expected 0 0", d, d_level);
      end
      @(negedge clk_sys);
      checks++;
      if (d !== 1'b0) begin
         errors++;
         $display("FAIL midreset_hold: got d=%b expected 0", d);
      end
      rst = 1'b0;
      while (cyc < t0 + 40) @(negedge clk_sys);
      d_raw = 1'b0;
      tick(30);
      checks++;
      if (d_q.size() != 3 || d_q[0] != t0 || d_q[1] != t0 + 20 || d_q[2] != t0 + 34) begin
         errors++;
         $display("FAIL midreset_pulses: got %0d pulses expected 3 at %0d %0d %0d",
                  d_q.size(), t0, t0 + 20, t0 + 34);
      end
      checks++;
      if (u_q.size() != 0) begin
         errors++;
         $display("FAIL midreset_up: got %0d up pulses expected 0", u_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_glitch();
      test_bounce();
      test_repeat();
      test_lockout();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
